// File: rtl/inst_fetch_queue_pkg.sv
// Core-wide fetch/decode constants shared by the instruction queue and its neighbours.
package inst_fetch_queue_pkg;

    localparam int unsigned INST_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0;
    localparam logic [ADDR_W-1:0] PC_RESET = 32'h0;

endpackage

// File: rtl/inst_fetch_queue.sv
// In-order {pc, inst} queue between fetch and decode with valid/ready on both sides
// and a single-cycle flush for branch/exception redirect.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = ADDR_W,
    parameter int unsigned IW    = INST_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_if_valid,
    input  logic [AW-1:0]              i_if_pc,
    input  logic [IW-1:0]              i_if_inst,
    output logic                       o_if_ready,
    output logic                       o_id_valid,
    output logic [AW-1:0]              o_id_pc,
    output logic [IW-1:0]              o_id_inst,
    input  logic                       i_id_ready,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW+IW-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_d;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on registered occupancy: a full queue refuses push even on pop.
    assign o_if_ready = (r_count != CW'(DEPTH));
    assign o_id_valid = (r_count != '0);
    assign o_count    = r_count;

    assign w_push = i_if_valid & o_if_ready;
    assign w_pop  = o_id_valid & i_id_ready;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CW'(1);
            2'b01:   w_count_d = r_count - CW'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= w_count_d;
        end
    end

    // Storage is never cleared; stale data is masked by o_id_valid below.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst && !i_flush) begin
            r_mem[r_wr_ptr] <= {i_if_pc, i_if_inst};
        end
    end

    always_comb begin
        o_id_pc   = AW'(PC_RESET);
        o_id_inst = IW'(NOP_INST);
        if (o_id_valid) begin
            {o_id_pc, o_id_inst} = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=4).
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready;
    logic [2:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch_queue #(.DEPTH(4), .AW(32), .IW(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_flush    (flush),
        .i_if_valid (if_valid),
        .i_if_pc    (if_pc),
        .i_if_inst  (if_inst),
        .o_if_ready (if_ready),
        .o_id_valid (id_valid),
        .o_id_pc    (id_pc),
        .o_id_inst  (id_inst),
        .i_id_ready (id_ready),
        .o_count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic v, input logic [31:0] pc);
        if_valid = v;
        if_pc    = pc;
        if_inst  = inst_of(pc);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input int cnt);
        check_eq({tag, "_valid"}, 64'(id_valid), 64'(1));
        check_eq({tag, "_pc"}, 64'(id_pc), 64'(pc));
        check_eq({tag, "_inst"}, 64'(id_inst), 64'(inst_of(pc)));
        check_eq({tag, "_count"}, 64'(count), 64'(cnt));
    endtask

    task automatic check_empty(input string tag);
        check_eq({tag, "_valid"}, 64'(id_valid), 64'(0));
        check_eq({tag, "_count"}, 64'(count), 64'(0));
        check_eq({tag, "_pc"}, 64'(id_pc), 64'(0));
        check_eq({tag, "_inst"}, 64'(id_inst), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        id_ready = 1'b0;
        drive_push(1'b1, 32'h100);

        // Reset held three cycles with fetch pushing.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_empty("rst");
        end
        rst = 1'b0;
        drive_push(1'b0, 32'h0);
        check_eq("rst_if_ready", 64'(if_ready), 64'(1));

        // Streaming with decode always ready.
        id_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_push(1'b1, 32'(4 * i));
            tick();
            check_head("stream", 32'(4 * i), 1);
        end
        drive_push(1'b0, 32'h0);
        tick();
        check_empty("stream_drain");

        // Fill to full with decode stalled.
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_push(1'b1, 32'(4 * i));
            tick();
        end
        check_head("full", 32'h0, 4);
        check_eq("full_if_ready", 64'(if_ready), 64'(0));
        drive_push(1'b1, 32'h10);
        tick();
        check_head("full_refuse", 32'h0, 4);
        id_ready = 1'b1;
        tick();
        check_head("full_pop1", 32'h4, 3);
        tick();
        check_head("full_pop2", 32'h8, 3);
        drive_push(1'b0, 32'h0);
        tick();
        check_head("full_pop3", 32'hC, 2);
        tick();
        check_head("full_pop4", 32'h10, 1);
        tick();
        check_empty("full_drain");

        // Simultaneous push/pop at count=2 across pointer wrap.
        id_ready = 1'b0;
        drive_push(1'b1, 32'h200);
        tick();
        drive_push(1'b1, 32'h204);
        tick();
        check_head("pp_start", 32'h200, 2);
        id_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_push(1'b1, 32'h208 + 32'(4 * k));
            tick();
            check_head("pp", 32'h204 + 32'(4 * k), 2);
        end
        drive_push(1'b0, 32'h0);
        tick();
        check_head("pp_tail", 32'h22C, 1);
        tick();
        check_empty("pp_drain");

        // Flush at count=3 with push and pop in the same cycle.
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(1'b1, 32'h300 + 32'(4 * i));
            tick();
        end
        check_head("fl_pre", 32'h300, 3);
        flush = 1'b1;
        id_ready = 1'b1;
        drive_push(1'b1, 32'h30C);
        tick();
        flush = 1'b0;
        id_ready = 1'b0;
        check_empty("fl_post");
        check_eq("fl_if_ready", 64'(if_ready), 64'(1));
        drive_push(1'b1, 32'h40);
        tick();
        drive_push(1'b0, 32'h0);
        check_head("fl_next", 32'h40, 1);
        id_ready = 1'b1;
        tick();
        check_empty("fl_drain");

        // Reset mid-stream at count=2, then fresh traffic.
        id_ready = 1'b0;
        drive_push(1'b1, 32'h500);
        tick();
        drive_push(1'b1, 32'h504);
        tick();
        check_head("mr_pre", 32'h500, 2);
        rst = 1'b1;
        drive_push(1'b0, 32'h0);
        tick();
        rst = 1'b0;
        check_empty("mr_post");
        drive_push(1'b1, 32'h600);
        tick();
        check_head("mr_new", 32'h600, 1);
        id_ready = 1'b1;
        drive_push(1'b1, 32'h604);
        tick();
        check_head("mr_new2", 32'h604, 1);
        drive_push(1'b0, 32'h0);
        tick();
        check_empty("mr_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
